// File: rtl/pop_router.sv
// -----------------------------------------------------------------------------
// pop_router
//
// Pops words from an upstream source FIFO and routes each one to one of two
// downstream FIFOs.  The destination is chosen by one bit of the data word:
// bit SEL_BIT = 0 goes to dest0 and bit SEL_BIT = 1 goes to dest1.  Only one
// word is in flight at a time.  This lets a destination that reports
// almost-full (depth-1 entries) still absorb the word that is already on its
// way.
//
// State table
//   state | meaning
//   IDLE  | waiting for the pop condition (enable, source not empty,
//         | neither destination almost full)
//   READ  | fifo_pop asserted; source presents the word next cycle
//   LATCH | source word on fifo_data; captured and pushed on the closing edge
//
// Ports
//   clk                  single clock, all state on posedge
//   reset                synchronous active-low reset
//   enable               permits new pops from the source FIFO
//   fifo_empty           source FIFO empty flag
//   fifo_data            source FIFO read data, valid the cycle after fifo_pop
//   fifo_pop             source FIFO read enable (high exactly in READ)
//   dest0_almost_full    dest0 almost-full flag
//   dest1_almost_full    dest1 almost-full flag
//   dest0_push           dest0 write enable (registered)
//   dest1_push           dest1 write enable (registered)
//   dest_data            registered word shared by both destinations
//   count0, count1       words pushed to dest0 / dest1, wrapping at 256
//   busy                 FSM not IDLE or a push is pending
// -----------------------------------------------------------------------------
module pop_router #(
    parameter int TAMANO_DATOS = 10,
    parameter int SEL_BIT      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    fifo_empty,
    input  logic [TAMANO_DATOS-1:0] fifo_data,
    output logic                    fifo_pop,
    input  logic                    dest0_almost_full,
    input  logic                    dest1_almost_full,
    output logic                    dest0_push,
    output logic                    dest1_push,
    output logic [TAMANO_DATOS-1:0] dest_data,
    output logic [7:0]              count0,
    output logic [7:0]              count1,
    output logic                    busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic pop_ok;
    logic capture;

    // New pops need every gate open; a word already popped completes anyway.
    assign pop_ok = enable & ~fifo_empty & ~dest0_almost_full & ~dest1_almost_full;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        fifo_pop   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (pop_ok) begin
                    state_next = READ;
                end
            end
            READ: begin
                fifo_pop   = 1'b1;
                state_next = LATCH;
            end
            LATCH: begin
                capture    = 1'b1;
                state_next = pop_ok ? READ : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The push for word k lands in the same cycle as the READ of word k+1,
    // which gives one word per two cycles at full rate.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dest_data  <= '0;
            dest0_push <= 1'b0;
            dest1_push <= 1'b0;
            count0     <= 8'd0;
            count1     <= 8'd0;
        end else begin
            dest0_push <= 1'b0;
            dest1_push <= 1'b0;
            if (capture) begin
                dest_data  <= fifo_data;
                dest0_push <= ~fifo_data[SEL_BIT];
                dest1_push <= fifo_data[SEL_BIT];
            end
            count0 <= count0 + {7'd0, dest0_push};
            count1 <= count1 + {7'd0, dest1_push};
        end
    end

    assign busy = (state != IDLE) | dest0_push | dest1_push;

endmodule

// File: tb/tb_pop_router.sv
// -----------------------------------------------------------------------------
// tb_pop_router
//
// Self-checking bench for pop_router.  A source FIFO model feeds the DUT.  An
// event-level reference model predicts the DUT outputs on every cycle:
//   - a pop happens when the pop condition held at the edge, no pop happened
//     in the previous cycle, and reset is high;
//   - a popped word is pushed two cycles later unless reset intervenes;
//   - the counters count pushes.
// The directed scenarios add literal expectations that pin the model itself.
// -----------------------------------------------------------------------------
module tb_pop_router;

    localparam int W   = 10;
    localparam int SEL = 8;

    logic         clk;
    logic         reset;
    logic         enable;
    logic         fifo_empty;
    logic [W-1:0] fifo_data;
    logic         fifo_pop;
    logic         dest0_almost_full;
    logic         dest1_almost_full;
    logic         dest0_push;
    logic         dest1_push;
    logic [W-1:0] dest_data;
    logic [7:0]   count0;
    logic [7:0]   count1;
    logic         busy;

    pop_router #(.TAMANO_DATOS(W), .SEL_BIT(SEL)) dut (
        .clk               (clk),
        .reset             (reset),
        .enable            (enable),
        .fifo_empty        (fifo_empty),
        .fifo_data         (fifo_data),
        .fifo_pop          (fifo_pop),
        .dest0_almost_full (dest0_almost_full),
        .dest1_almost_full (dest1_almost_full),
        .dest0_push        (dest0_push),
        .dest1_push        (dest1_push),
        .dest_data         (dest_data),
        .count0            (count0),
        .count1            (count1),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- source FIFO model and stimulus helpers ----------------
    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_q[$];
    logic         saw_pop;
    int           n_push0;
    int           n_push1;

    // Inputs only change here, at the negedge, after the current cycle's
    // outputs have settled.
    task automatic step();
        @(negedge clk);
        saw_pop = fifo_pop;
        n_push0 += int'(dest0_push);
        n_push1 += int'(dest1_push);
        if (fifo_pop) begin
            check("pop_nonempty", 32'(src_q.size() != 0), 32'd1);
            if (src_q.size() != 0) fifo_data = src_q.pop_front();
        end
        fifo_empty = (src_q.size() == 0);
    endtask

    task automatic load(input logic [W-1:0] w);
        src_q.push_back(w);
        exp_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_pop(input int max_cycles);
        int k;
        k = 0;
        saw_pop = 1'b0;
        while (!saw_pop && k < max_cycles) begin
            step();
            k++;
        end
        check("wait_pop_timeout", 32'(saw_pop), 32'd1);
    endtask

    task automatic drain(input int n);
        enable = 1'b1;
        dest0_almost_full = 1'b0;
        dest1_almost_full = 1'b0;
        repeat (n) step();
        enable = 1'b0;
        repeat (4) step();
    endtask

    // ---------------- reference model and per-cycle compare ----------------
    logic         m_pop    = 1'b0;
    logic         m_latch  = 1'b0;
    logic         m_push0  = 1'b0;
    logic         m_push1  = 1'b0;
    logic [W-1:0] m_wpop   = '0;
    logic [W-1:0] m_wlatch = '0;
    logic [W-1:0] m_data   = '0;
    logic [7:0]   m_c0     = 8'd0;
    logic [7:0]   m_c1     = 8'd0;
    logic         e_rst;
    logic         e_cond;
    logic         old_pop;
    logic         old_latch;
    logic [W-1:0] old_wlatch;

    always @(posedge clk) begin
        e_rst  = reset;
        e_cond = enable && !fifo_empty && !dest0_almost_full && !dest1_almost_full;
        if (!e_rst) begin
            m_pop = 1'b0; m_latch = 1'b0; m_push0 = 1'b0; m_push1 = 1'b0;
            m_data = '0; m_c0 = 8'd0; m_c1 = 8'd0;
        end else begin
            old_pop    = m_pop;
            old_latch  = m_latch;
            old_wlatch = m_wlatch;
            m_c0 = m_c0 + 8'(m_push0);
            m_c1 = m_c1 + 8'(m_push1);
            // A word is routed two cycles after its pop.
            m_push0 = old_latch && !old_wlatch[SEL];
            m_push1 = old_latch && old_wlatch[SEL];
            if (old_latch) m_data = old_wlatch;
            m_latch  = old_pop;
            m_wlatch = m_wpop;
            // Never pop back to back; otherwise pop whenever allowed.
            m_pop = !old_pop && e_cond;
            if (m_pop && exp_q.size() != 0) m_wpop = exp_q.pop_front();
        end
        #1;
        check("fifo_pop",   32'(fifo_pop),   32'(m_pop));
        check("dest0_push", 32'(dest0_push), 32'(m_push0));
        check("dest1_push", 32'(dest1_push), 32'(m_push1));
        check("dest_data",  32'(dest_data),  32'(m_data));
        check("count0",     32'(count0),     32'(m_c0));
        check("count1",     32'(count1),     32'(m_c1));
        check("busy",       32'(busy),       32'(m_pop | m_latch | m_push0 | m_push1));
    end

    // ---------------- stimulus ----------------
    int c_before;

    initial begin
        reset = 1'b0;
        enable = 1'b1;
        fifo_empty = 1'b1;
        fifo_data = '0;
        dest0_almost_full = 1'b0;
        dest1_almost_full = 1'b0;
        saw_pop = 1'b0;
        n_push0 = 0;
        n_push1 = 0;

        // Reset with a non-empty source and enable high.
        load(10'h0FF);
        load(10'h1AA);
        repeat (3) begin
            step();
            check("rst_pop", 32'(fifo_pop), 32'd0);
            check("rst_push", 32'({dest0_push, dest1_push}), 32'd0);
            check("rst_counts", 32'({count0, count1}), 32'd0);
        end
        reset = 1'b1;

        // Two words through idle destinations.
        step(); check("first_pop", 32'(fifo_pop), 32'd1);
        step(); check("latch_no_pop", 32'(fifo_pop), 32'd0);
                check("latch_no_push", 32'(dest0_push), 32'd0);
        step(); check("w0_push0", 32'(dest0_push), 32'd1);
                check("w0_data", 32'(dest_data), 32'h0FF);
                check("w1_pop_overlap", 32'(fifo_pop), 32'd1);
        step();
        step(); check("w1_push1", 32'(dest1_push), 32'd1);
                check("w1_push0_low", 32'(dest0_push), 32'd0);
                check("w1_data", 32'(dest_data), 32'h1AA);
                check("w1_count0", 32'(count0), 32'd1);
        step(); check("end_count1", 32'(count1), 32'd1);
                check("end_count0", 32'(count0), 32'd1);
                check("end_busy", 32'(busy), 32'd0);
                check("hold_data", 32'(dest_data), 32'h1AA);

        // Six words back to back.
        c_before = n_push0 + n_push1;
        for (int i = 0; i < 6; i++) load(W'($urandom));
        repeat (16) step();
        check("six_pushes", 32'(n_push0 + n_push1 - c_before), 32'd6);

        // Almost-full rises while a word is in LATCH.
        enable = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 3; i++) load(10'h100 | W'(i));
        enable = 1'b1;
        wait_pop(10);
        step();
        dest1_almost_full = 1'b1;
        step(); check("af_push_completes", 32'(dest0_push | dest1_push), 32'd1);
        repeat (5) begin
            step(); check("af_no_pop", 32'(fifo_pop), 32'd0);
        end
        dest1_almost_full = 1'b0;
        drain(10);

        // Enable dropped in a READ cycle.
        for (int i = 0; i < 3; i++) load(W'(i + 5));
        enable = 1'b1;
        wait_pop(10);
        enable = 1'b0;
        step();
        step(); check("en_push_completes", 32'(dest0_push), 32'd1);
        repeat (4) begin
            step(); check("en_no_pop", 32'(fifo_pop), 32'd0);
                    check("en_idle", 32'(dest0_push | dest1_push | busy), 32'd0);
        end
        drain(10);

        // 256 words all routed to dest0 from a fresh reset: count0 wraps.
        reset = 1'b0;
        repeat (2) step();
        reset = 1'b1;
        n_push0 = 0;
        n_push1 = 0;
        for (int i = 0; i < 256; i++) load(W'($urandom) & ~(W'(1) << SEL));
        enable = 1'b1;
        for (int k = 0; k < 700 && (src_q.size() != 0 || busy); k++) step();
        repeat (3) step();
        check("wrap_pushes0", 32'(n_push0), 32'd256);
        check("wrap_count0", 32'(count0), 32'd0);
        check("wrap_count1", 32'(count1), 32'd0);

        // Reset in a LATCH cycle discards the word.
        load(10'h1F0);
        wait_pop(10);
        step();
        reset = 1'b0;
        step(); check("rst_latch_no_push", 32'(dest0_push | dest1_push), 32'd0);
        reset = 1'b1;
        enable = 1'b0;
        step(); check("rst_latch_no_push2", 32'(dest0_push | dest1_push), 32'd0);
                check("rst_latch_data", 32'(dest_data), 32'd0);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 2) == 0 && src_q.size() < 8) load(W'($urandom));
            enable            = ($urandom_range(0, 7) != 0);
            dest0_almost_full = ($urandom_range(0, 9) == 0);
            dest1_almost_full = ($urandom_range(0, 9) == 0);
            reset             = ($urandom_range(0, 199) != 0);
            step();
        end
        reset = 1'b1;
        drain(40);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
